btn_debounce: RTL

//   Debounces NUM_BTN raw push-button inputs using the 1 kHz single-cycle tick_en strobe from the clock-enable stage.

---
 rtl/btn_debounce_pkg.sv | 15 +
 rtl/btn_debounce_cell.sv | 120 ++++++++++++
 rtl/btn_debounce.sv | 42 ++++
 3 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b11,
        RELEASE_WAIT = 2'b10
    } state_t;

    localparam int DEF_NUM_BTN      = 5;
    localparam int DEF_STABLE_TICKS = 20;
    localparam int DEF_HOLD_TICKS   = 1000;

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop synchronizer, debounce FSM with tick counter, registered pulses.
// Long-press detection is built only when LONG_PRESS_EN is defined.
module debounce_cell
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
`ifdef LONG_PRESS_EN
    , parameter int HOLD_TICKS = DEF_HOLD_TICKS
`endif
) (
    input  logic clk_in,
    input  logic clr_n,
    input  logic tick_en,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          sync_a;
    logic          sync_b;
    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in or negedge clr_n) begin
        if (!clr_n) begin
            sync_a        <= 1'b0;
            sync_b        <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_a        <= raw;
            sync_b        <= sync_a;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_b) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                // Any low sample aborts, even one falling between ticks.
                PRESS_WAIT: begin
                    if (!sync_b) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (tick_en) begin
                        if (cnt == CNT_LAST) begin
                            state       <= PRESSED;
                            cnt         <= '0;
                            level       <= 1'b1;
                            press_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!sync_b) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_b) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (tick_en) begin
                        if (cnt == CNT_LAST) begin
                            state         <= IDLE;
                            cnt           <= '0;
                            level         <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LONG_PRESS_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

    logic [HW-1:0] hold_cnt;

    // Cleared only once the button is fully released, so release bounces keep the count.
    always_ff @(posedge clk_in or negedge clr_n) begin
        if (!clr_n) begin
            hold_cnt   <= '0;
            hold_pulse <= 1'b0;
        end else begin
            hold_pulse <= 1'b0;
            if (state == IDLE) begin
                hold_cnt <= '0;
            end else if (state == PRESSED && tick_en && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    hold_pulse <= 1'b1;
                end
            end
        end
    end
`else
    assign hold_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Debounces NUM_BTN independent buttons with one debounce_cell per bit.
// Define LONG_PRESS_EN to enable the btn_hold long-press pulse.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NUM_BTN      = DEF_NUM_BTN,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
    input  logic               clk_in,
    input  logic               clr_n,
    input  logic               tick_en,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_hold
);

    if (STABLE_TICKS < 1 || HOLD_TICKS < 1) begin : g_bad_param
        $error("btn_debounce: STABLE_TICKS and HOLD_TICKS must be >= 1");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS)
`ifdef LONG_PRESS_EN
            , .HOLD_TICKS (HOLD_TICKS)
`endif
        ) u_cell (
            .clk_in        (clk_in),
            .clr_n         (clr_n),
            .tick_en       (tick_en),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .hold_pulse    (btn_hold[i])
        );
    end

endmodule
